// File: rtl/contador_programa_pkg.sv
// rtl/contador_programa_pkg.sv - FSM states and next-address select codes
package pc_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    ISR    = 2'd2
  } estado_t;

  typedef enum logic [3:0] {
    SEL_RECUPERA = 4'd0,
    SEL_INT      = 4'd1,
    SEL_RETI     = 4'd2,
    SEL_HOLD     = 4'd3,
    SEL_BRANCH   = 4'd4,
    SEL_JUMP     = 4'd5,
    SEL_JR       = 4'd6,
    SEL_JAL      = 4'd7,
    SEL_RET      = 4'd8,
    SEL_HALT     = 4'd9,
    SEL_SEQ      = 4'd10
  } sel_t;

  // First match wins; the unused state code 3 falls back to RUN before anything else.
  function automatic sel_t prioridade(
    input logic [1:0] estado,
    input logic       interrupt,
    input logic       reti,
    input logic       tomado,
    input logic       jump,
    input logic       jr,
    input logic       jal,
    input logic       ret,
    input logic       halt
  );
    sel_t s;
    if (estado == 2'd3)                                 s = SEL_RECUPERA;
    else if (interrupt && (estado == RUN || estado == HALTED)) s = SEL_INT;
    else if (reti && estado == ISR)                     s = SEL_RETI;
    else if (estado == HALTED)                          s = SEL_HOLD;
    else if (tomado)                                    s = SEL_BRANCH;
    else if (jump)                                      s = SEL_JUMP;
    else if (jr)                                        s = SEL_JR;
    else if (jal)                                       s = SEL_JAL;
    else if (ret)                                       s = SEL_RET;
    else if (halt)                                      s = SEL_HALT;
    else                                                s = SEL_SEQ;
    return s;
  endfunction

endpackage

// File: rtl/contador_programa_if.sv
// rtl/contador_programa_if.sv - control-unit side bundle of the program counter
interface contador_programa_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int RAS_DEPTH  = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] desvio_condicional;
  logic [ADDR_WIDTH-1:0] desvio_incondicional;
  logic [ADDR_WIDTH-1:0] desvio_jal;
  logic [ADDR_WIDTH-1:0] leitura1;
  logic                  Branch;
  logic                  BranchNE;
  logic                  Jump;
  logic                  Jr;
  logic                  Jal;
  logic                  Ret;
  logic                  Reti;
  logic                  Halt;
  logic                  zero;
  logic                  stall;
  logic                  interrupt;

  logic [ADDR_WIDTH-1:0] cp;
  logic [ADDR_WIDTH-1:0] link;
  logic [1:0]            estado;
  logic [CW-1:0]         ras_count;
  logic                  ras_overflow;
  logic                  ras_underflow;

  modport master (
    output desvio_condicional, desvio_incondicional, desvio_jal, leitura1,
    output Branch, BranchNE, Jump, Jr, Jal, Ret, Reti, Halt, zero, stall, interrupt,
    input  cp, link, estado, ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  desvio_condicional, desvio_incondicional, desvio_jal, leitura1,
    input  Branch, BranchNE, Jump, Jr, Jal, Ret, Reti, Halt, zero, stall, interrupt,
    output cp, link, estado, ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/contador_programa_pilha_retorno.sv
// rtl/contador_programa_pilha_retorno.sv - circular return-address stack
module pilha_retorno #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] UM_P  = PW'(1);
  localparam logic [CW-1:0] UM_C  = CW'(1);
  localparam logic [CW-1:0] CHEIO = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    ptr;

  // ptr is the next free slot, so the top of stack sits one below it.
  assign dout = mem[ptr - UM_P];

  always_ff @(posedge clock) begin
    if (push) mem[ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (push) begin
      ptr <= ptr + UM_P;
      if (count == CHEIO) overflow <= 1'b1;
      else                count    <= count + UM_C;
    end else if (pop) begin
      if (count == '0) begin
        underflow <= 1'b1;
      end else begin
        ptr   <= ptr - UM_P;
        count <= count - UM_C;
      end
    end
  end

endmodule

// File: rtl/contador_programa.sv
// rtl/contador_programa.sv - program counter with return stack, interrupt entry and halt
module contador_programa
  import pc_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 6,
  parameter int                    RAS_DEPTH  = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] INT_VECTOR = ADDR_WIDTH'((2 ** ADDR_WIDTH) - 4)
) (
  input  logic                 clock,
  input  logic                 reset,
  contador_programa_if.slave   bus
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] UM = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] cp_q;
  logic [ADDR_WIDTH-1:0] epc_q;
  logic [1:0]            estado_q;
  logic [ADDR_WIDTH-1:0] cp_mais1;
  logic [ADDR_WIDTH-1:0] ras_dout;
  logic [CW-1:0]         ras_count;
  logic                  ras_overflow;
  logic                  ras_underflow;
  logic                  tomado;
  logic                  push;
  logic                  pop;
  sel_t                  sel;

  assign cp_mais1 = cp_q + UM;
  assign tomado   = (bus.Branch & bus.zero) | (bus.BranchNE & ~bus.zero);
  assign sel      = prioridade(estado_q, bus.interrupt, bus.Reti, tomado,
                               bus.Jump, bus.Jr, bus.Jal, bus.Ret, bus.Halt);

  assign push = ~bus.stall & (sel == SEL_JAL);
  assign pop  = ~bus.stall & (sel == SEL_RET);

  pilha_retorno #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_pilha (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .din       (cp_mais1),
    .dout      (ras_dout),
    .count     (ras_count),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      cp_q     <= RESET_ADDR;
      epc_q    <= '0;
      estado_q <= RUN;
    end else if (!bus.stall) begin
      case (sel)
        SEL_RECUPERA: begin
          estado_q <= RUN;
          cp_q     <= cp_mais1;
        end
        SEL_INT: begin
          // A halted core resumes at the halt itself; a running one at the next instruction.
          epc_q    <= (estado_q == RUN) ? cp_mais1 : cp_q;
          cp_q     <= INT_VECTOR;
          estado_q <= ISR;
        end
        SEL_RETI: begin
          cp_q     <= epc_q;
          estado_q <= RUN;
        end
        SEL_HOLD:   cp_q <= cp_q;
        SEL_BRANCH: cp_q <= cp_mais1 + bus.desvio_condicional;
        SEL_JUMP:   cp_q <= bus.desvio_incondicional;
        SEL_JR:     cp_q <= bus.leitura1;
        SEL_JAL:    cp_q <= bus.desvio_jal;
        SEL_RET:    cp_q <= (ras_count == '0) ? cp_mais1 : ras_dout;
        SEL_HALT:   estado_q <= HALTED;
        default:    cp_q <= cp_mais1;
      endcase
    end
  end

  assign bus.cp            = cp_q;
  assign bus.link          = cp_mais1;
  assign bus.estado        = estado_q;
  assign bus.ras_count     = ras_count;
  assign bus.ras_overflow  = ras_overflow;
  assign bus.ras_underflow = ras_underflow;

endmodule

// File: tb/tb_contador_programa.sv
// tb/tb_contador_programa.sv - directed self-checking bench for contador_programa
module tb_contador_programa;
  localparam int AW = 6;
  localparam int RD = 4;
  localparam int IV = 60;

  logic clock = 1'b0;
  logic reset;
  int   testes = 0;
  int   falhas = 0;

  always #5 clock = ~clock;

  contador_programa_if #(.ADDR_WIDTH(AW), .RAS_DEPTH(RD)) bus ();

  contador_programa #(.ADDR_WIDTH(AW), .RAS_DEPTH(RD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic confere(input string tag, input int obs, input int esp);
    testes++;
    if (obs !== esp) begin
      falhas++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, esp);
    end
  endtask

  task automatic limpa();
    bus.desvio_condicional   = '0;
    bus.desvio_incondicional = '0;
    bus.desvio_jal           = '0;
    bus.leitura1             = '0;
    bus.Branch = 0; bus.BranchNE = 0; bus.Jump = 0; bus.Jr = 0;
    bus.Jal = 0; bus.Ret = 0; bus.Reti = 0; bus.Halt = 0;
    bus.zero = 0; bus.stall = 0; bus.interrupt = 0;
  endtask

  // One edge with the strobes already set, then check cp and release the strobes.
  task automatic ciclo(input string tag, input int esp_cp);
    @(posedge clock);
    #1;
    confere(tag, int'(bus.cp), esp_cp);
    limpa();
  endtask

  task automatic salta(input int alvo);
    bus.Jump = 1; bus.desvio_incondicional = AW'(alvo);
    ciclo("jump", alvo);
  endtask

  task automatic chama(input int alvo, input int esp_count);
    bus.Jal = 1; bus.desvio_jal = AW'(alvo);
    ciclo("jal_cp", alvo);
    confere("jal_count", int'(bus.ras_count), esp_count);
  endtask

  task automatic retorna(input int esp_cp, input int esp_count);
    bus.Ret = 1;
    ciclo("ret_cp", esp_cp);
    confere("ret_count", int'(bus.ras_count), esp_count);
  endtask

  initial begin
    limpa();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    confere("rst_cp", int'(bus.cp), 0);
    confere("rst_estado", int'(bus.estado), 0);
    confere("rst_count", int'(bus.ras_count), 0);
    confere("rst_ovf", int'(bus.ras_overflow), 0);
    confere("rst_udf", int'(bus.ras_underflow), 0);
    confere("rst_link", int'(bus.link), 1);
    for (int i = 1; i <= 5; i++) ciclo("idle", i);

    salta(10);
    bus.Branch = 1; bus.zero = 1; bus.desvio_condicional = 6'b111100;
    ciclo("beq_taken", 7);
    bus.BranchNE = 1; bus.zero = 1; bus.desvio_condicional = 6'd5;
    ciclo("bne_not_taken", 8);
    bus.Branch = 1; bus.zero = 0; bus.desvio_condicional = 6'd5;
    ciclo("beq_not_taken", 9);
    bus.BranchNE = 1; bus.zero = 0; bus.desvio_condicional = 6'd3;
    ciclo("bne_taken", 13);
    salta(63);
    confere("link_wrap", int'(bus.link), 0);
    ciclo("wrap", 0);

    salta(3);
    confere("link_before_jal", int'(bus.link), 4);
    chama(20, 1);
    salta(21);
    chama(30, 2);
    retorna(22, 1);
    retorna(4, 0);

    chama(10, 1);
    chama(20, 2);
    chama(30, 3);
    chama(40, 4);
    confere("ovf_before", int'(bus.ras_overflow), 0);
    chama(50, 4);
    confere("ovf_set", int'(bus.ras_overflow), 1);
    retorna(41, 3);
    retorna(31, 2);
    retorna(21, 1);
    retorna(11, 0);
    confere("udf_before", int'(bus.ras_underflow), 0);
    retorna(12, 0);
    confere("udf_set", int'(bus.ras_underflow), 1);
    confere("ovf_sticky", int'(bus.ras_overflow), 1);

    bus.Jr = 1; bus.leitura1 = 6'd33;
    ciclo("jr", 33);

    salta(8);
    bus.Halt = 1;
    ciclo("halt_cp", 8);
    confere("halt_estado", int'(bus.estado), 1);
    ciclo("halted_hold", 8);
    bus.interrupt = 1;
    ciclo("int_halted_cp", IV);
    confere("int_estado", int'(bus.estado), 2);
    bus.interrupt = 1;
    ciclo("int_masked", IV + 1);
    bus.Reti = 1;
    ciclo("reti_cp", 8);
    confere("reti_estado", int'(bus.estado), 0);
    ciclo("after_reti", 9);
    bus.interrupt = 1; bus.Jump = 1; bus.desvio_incondicional = 6'd40;
    ciclo("int_run_cp", IV);
    bus.Reti = 1;
    ciclo("reti_run", 10);
    bus.Reti = 1;
    ciclo("reti_outside_isr", 11);

    for (int i = 0; i < 3; i++) begin
      bus.stall = 1; bus.Jump = 1; bus.desvio_incondicional = 6'd40;
      ciclo("stall_cp", 11);
      confere("stall_link", int'(bus.link), 12);
    end
    bus.stall = 1; bus.Jal = 1; bus.desvio_jal = 6'd25;
    ciclo("stall_jal_cp", 11);
    confere("stall_jal_count", int'(bus.ras_count), 0);

    bus.stall = 1;
    reset = 1'b1;
    ciclo("rst_stall_cp", 0);
    reset = 1'b0;
    confere("rst_stall_ovf", int'(bus.ras_overflow), 0);
    confere("rst_stall_udf", int'(bus.ras_underflow), 0);
    confere("rst_stall_estado", int'(bus.estado), 0);
    ciclo("post_rst", 1);

    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule

// File: doc/contador_programa.md
# contador_programa

Parametrised program-counter unit for the single-cycle datapath. Each clock edge it selects the next instruction address from sequential increment, PC-relative branch, absolute jump, register jump, or call/return. It adds a hardware return-address stack, an interrupt entry/return path, a halt state and a pipeline stall. It sits in front of instruction memory and drives its address; its decode inputs come from the control unit.

## Interface
- ADDR_WIDTH, 6, instruction address width.
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2).
- RESET_ADDR, 0, cp value after reset.
- INT_VECTOR, 2**ADDR_WIDTH-4, interrupt entry address.
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state on the rising edge it is sampled high.
- desvio_condicional  in  ADDR_WIDTH  signed two's-complement branch offset.
- desvio_incondicional  in  ADDR_WIDTH  absolute Jump target.
- desvio_jal  in  ADDR_WIDTH  absolute Jal target.
- leitura1  in  ADDR_WIDTH  register-file read port 1 (Jr target).
- Branch, BranchNE, Jump, Jr, Jal, Ret, Reti, Halt  in  1 each  decoded control strobes.
- zero  in  1  ALU zero flag.
- stall  in  1  freeze all state this cycle.
- interrupt  in  1  level interrupt request.
- cp  out  ADDR_WIDTH  current instruction address (registered).
- link  out  ADDR_WIDTH  cp+1, combinational, for register-file link writeback.
- estado  out  2  FSM state.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid stack entries.
- ras_overflow, ras_underflow  out  1 each  sticky error flags.

## Operation
- FSM states: RUN=0, HALTED=1, ISR=2. Encoding 3 is unused; if reached, go to RUN on the next non-stalled edge.
- Reset values: cp=RESET_ADDR, estado=RUN, epc=0, ras_count=0, both flags 0, stack contents don't-care.
- Per non-stalled edge, first match wins:
  1. interrupt while estado∈{RUN,HALTED}: epc←(RUN ? cp+1 : cp), cp←INT_VECTOR, estado←ISR.
  2. Reti while ISR: cp←epc, estado←RUN.
  3. HALTED, no interrupt: hold cp.
  4. (Branch & zero) | (BranchNE & ~zero): cp←cp+1+sext(desvio_condicional).
  5. Jump: cp←desvio_incondicional.
  6. Jr: cp←leitura1.
  7. Jal: push cp+1, then cp←desvio_jal.
  8. Ret: pop; cp←popped value.
  9. Halt: estado←HALTED, cp held.
  10. else cp←cp+1.
- Interrupts are masked in ISR; nesting is not supported. Reti outside ISR is ignored and falls through the list.
- Arithmetic is modulo 2^ADDR_WIDTH; wrap from all-ones to 0 is legal, not an error.
- Push when full: overwrite the oldest entry (circular), ras_count stays RAS_DEPTH, ras_overflow←1.
- Pop when empty: cp←cp+1, ras_count stays 0, ras_underflow←1.
- Flags clear only on reset.
- stall=1: cp, estado, epc, stack and flags all hold; link still tracks cp.
- reset has priority over stall and over every strobe.

## Timing
- Zero-latency decision: inputs sampled on edge N give the new cp after edge N. One instruction per cycle.
- link is valid in the same cycle as cp. Jal's writeback uses link before the edge.
- Push and pop never occur in the same cycle, because the priority list makes them exclusive.
- Interrupt is level-sensitive and sampled each non-stalled edge; the source holds it until acknowledged by the ISR.

## Structure
- Package pc_pkg: estado_t enum (RUN, HALTED, ISR) and the priority-select encoding constants.
- Sub-module pilha_retorno(DEPTH, WIDTH): circular return stack.
  - Ports: push, pop, din, dout, count, overflow, underflow.
  - Ring pointer plus saturating counter.
- Top holds the FSM, epc and next-cp mux.

## Test plan
- Reset then 5 idle cycles -> cp 0,1,2,3,4,5; estado=0; flags 0.
- At cp=10, Branch=1, zero=1, offset=6'b111100 (-4) -> cp=7. At cp=63, no strobe -> cp=0 (wrap).
- Jal to 20 at cp=3, Jal to 30 at cp=21, Ret, Ret -> cp sequence 20,30,22,4; ras_count 1,2,1,0.
- RAS_DEPTH=4: five nested Jal -> ras_overflow=1, ras_count=4; fifth Ret -> underflow=1, cp=cp+1.
- Halt at cp=8 -> cp holds 8. Interrupt -> cp=INT_VECTOR, estado=2, epc=8. Reti -> cp=8, estado=0.
- stall=1 for 3 cycles during Jump=1 -> cp and ras_count unchanged. reset asserted with stall=1 -> cp=RESET_ADDR next edge.
